// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse cipher.
// Contents: round/key-length constants, FSM state enum, Rcon lookup,
// FIPS-197 byte/word helpers and the GF(2^8) helpers used by the
// inverse round (xtime, gmul9/b/d/e, inv_shift_rows, inv_mix_column).
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, HOLD} fsm_t;

  // Rcon[i] for i = 1..10; anything else maps to zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Byte i of a block; byte 0 sits in bits [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
    get_byte = s[127-8*i -: 8];
  endfunction

  // Word i of a block; word 0 sits in bits [127:96].
  function automatic logic [31:0] get_word(input logic [127:0] s, input int i);
    get_word = s[127-32*i -: 32];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    gmul9 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    gmulb = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    gmuld = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    gmule = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row r of the column-major state rotates right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = get_byte(s, r + 4*((c + 4 - r) % 4));
      end
    end
    inv_shift_rows = o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    inv_mix_column = {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
                      gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
                      gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
                      gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, pure combinational table lookup.
// Ports: x - input byte, y - inverse-substituted byte.
module aes_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y = TBL[x];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational table lookup.
// Ports: x - input byte, y - substituted byte.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TBL[x];

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 inverse cipher.
// The key is first expanded forward to rk10 (10 cycles), then each inverse
// round steps the key schedule back by one round key while decrypting, so
// only a single 128-bit key register is needed.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - job handshake; state = ciphertext, key = cipher key
//   out_valid/out_ready - result handshake; out = plaintext
// All blocks use FIPS-197 byte order (byte 0 in bits [127:120]).
module aes_128_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam logic [3:0] LAST_RND = 4'(NR - 1);

  fsm_t         fsm_reg, fsm_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic [127:0] data_reg, data_next;
  logic [127:0] key_reg, key_next;
  logic [127:0] out_reg, out_next;
  logic         out_valid_reg, out_valid_next;

  // Key schedule: one shared SubWord(RotWord()) datapath. During KEYEXP it
  // takes w3 of the current key (forward step); during ROUND it takes the
  // recovered w3 = w7 ^ w6 (backward step). Both use Rcon[cnt + 1].
  logic [31:0]  kw [NK];
  logic [31:0]  bw3, sub_in, sub_out, t_word;
  logic [31:0]  fw [NK];
  logic [127:0] key_fwd, key_back;

  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_kw
      assign kw[gi] = get_word(key_reg, gi);
    end
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (.x(sub_in[31-8*gi -: 8]), .y(sub_out[31-8*gi -: 8]));
    end
  endgenerate

  assign bw3    = kw[3] ^ kw[2];
  assign sub_in = (fsm_reg == KEYEXP) ? {kw[3][23:0], kw[3][31:24]}
                                      : {bw3[23:0], bw3[31:24]};
  assign t_word = sub_out ^ {rcon(cnt_reg + 4'd1), 24'h000000};

  assign fw[0]   = kw[0] ^ t_word;
  assign fw[1]   = kw[1] ^ fw[0];
  assign fw[2]   = kw[2] ^ fw[1];
  assign fw[3]   = kw[3] ^ fw[2];
  assign key_fwd = {fw[0], fw[1], fw[2], fw[3]};

  assign key_back = {kw[0] ^ t_word, kw[1] ^ kw[0], kw[2] ^ kw[1], bw3};

  // Inverse round datapath. InvSubBytes is bytewise, so it is applied after
  // the byte permutation of InvShiftRows without reordering issues.
  logic [127:0] shifted, subbed, ark, mixed, rnd_out;

  assign shifted = inv_shift_rows(data_reg);

  generate
    for (gi = 0; gi < 16; gi++) begin : g_isbox
      aes_inv_sbox u_isbox (.x(shifted[127-8*gi -: 8]), .y(subbed[127-8*gi -: 8]));
    end
  endgenerate

  assign ark = subbed ^ key_back;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_imix
      assign mixed[127-32*gi -: 32] = inv_mix_column(ark[127-32*gi -: 32]);
    end
  endgenerate

  // The final round (r = 0) has no InvMixColumns.
  assign rnd_out = (cnt_reg == 4'd0) ? ark : mixed;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      cnt_reg       <= 4'd0;
      data_reg      <= '0;
      key_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      cnt_reg       <= cnt_next;
      data_reg      <= data_next;
      key_reg       <= key_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    fsm_next       = fsm_reg;
    cnt_next       = cnt_reg;
    data_next      = data_reg;
    key_next       = key_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    case (fsm_reg)
      IDLE: begin
        if (in_valid) begin
          data_next = state;
          key_next  = key;
          cnt_next  = 4'd0;
          fsm_next  = KEYEXP;
        end
      end
      KEYEXP: begin
        key_next = key_fwd;
        if (cnt_reg == LAST_RND) begin
          // Counter stays at 9: it becomes the first inverse round index.
          data_next = data_reg ^ key_fwd;
          fsm_next  = ROUND;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ROUND: begin
        data_next = rnd_out;
        key_next  = key_back;
        if (cnt_reg == 4'd0) begin
          out_next       = rnd_out;
          out_valid_next = 1'b1;
          fsm_next       = HOLD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          fsm_next       = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign in_ready  = (fsm_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Bench for aes_128_decrypt: expected plaintexts are queued on acceptance
// and compared on the output handshake, with latency checked on out_valid rise.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] state, key, out;

  typedef struct {
    logic [127:0] pt;
    int           t;
  } job_t;

  job_t         sb_q[$];
  logic [127:0] exp_pt;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic         ov_prev = 1'b0;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  aes_128_decrypt dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state    (state),
    .key      (key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    job_t j;
    if (!rst) begin
      if (in_valid && in_ready) sb_q.push_back('{exp_pt, cyc});
      if (out_valid && !ov_prev) begin
        check_eq("job_pending", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) check_eq("latency", 128'(cyc - sb_q[0].t), 128'd21);
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        j = sb_q.pop_front();
        check_eq("plaintext", out, j.pt);
        $display("txn accepted_cyc=%0d done_cyc=%0d out=%h exp=%h", j.t, cyc, out, j.pt);
      end
    end
    ov_prev = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check_eq("send_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    key      = k;
    state    = ct;
    exp_pt   = pt;
    step();
    in_valid = 1'b0;
    key      = {$urandom, $urandom, $urandom, $urandom};
    state    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 200) begin
      step();
      n++;
    end
    check_eq("drain", 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    state = '0; key = '0; exp_pt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_out", out, 128'd0);
    rst = 1'b0;

    // FIPS-197 Appendix B and C.1 vectors.
    send(K1, C1, P1);
    drain();
    send(K2, C2, P2);
    drain();

    // Back-to-back jobs with out_ready held high.
    send(128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'd0);
    send(128'd1, 128'h0545aad56da2a97c3663d1432a3d1c84, 128'd0);
    send(128'd0, 128'h58e2fccefa7e3061367f1d57a4e7455a, 128'd1);
    drain();

    // Backpressure: result must hold, new requests must be ignored.
    out_ready = 1'b0;
    send(K1, C1, P1);
    for (int n = 0; n < 40 && !out_valid; n++) step();
    check_eq("bp_valid_seen", 128'(out_valid), 128'd1);
    for (int i = 0; i < 15; i++) begin
      check_eq("bp_out_stable", out, P1);
      check_eq("bp_in_ready", 128'(in_ready), 128'd0);
      check_eq("bp_out_valid", 128'(out_valid), 128'd1);
      in_valid = (i == 5);
      key      = K2;
      state    = C2;
      exp_pt   = P2 ^ 128'd1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_valid_drop", 128'(out_valid), 128'd0);
    check_eq("bp_ready_back", 128'(in_ready), 128'd1);
    check_eq("bp_out_kept", out, P1);
    check_eq("bp_single", 128'(sb_q.size()), 128'd0);
    out_ready = 1'b1;

    // Reset in the middle of the inverse rounds.
    send(K2, C2, P2);
    repeat (14) step();
    rst = 1'b1;
    sb_q.delete();
    step();
    check_eq("abort_in_ready", 128'(in_ready), 128'd1);
    check_eq("abort_out_valid", 128'(out_valid), 128'd0);
    check_eq("abort_out", out, 128'd0);
    rst = 1'b0;
    send(K1, C1, P1);
    drain();

    // A request during key expansion must not disturb the running job.
    send(K2, C2, P2);
    step();
    step();
    in_valid = 1'b1;
    key      = K1;
    state    = C1;
    exp_pt   = P1;
    step();
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
